// File: rtl/riscv_dm_sri_arbiter_pkg.sv
// Shared types and constants for the Debug Module SRI arbiter.
package riscv_dm_sri_arbiter_pkg;

  localparam int unsigned SRI_ARB_MAX_REQ = 16;
  localparam int unsigned SRI_ADDR_WIDTH  = 6;
  localparam int unsigned SRI_DATA_WIDTH  = 64;
  localparam int unsigned SRI_BE_WIDTH    = SRI_DATA_WIDTH / 8;

  // One SRI access as presented to the DM slave port.
  typedef struct packed {
    logic                      en;
    logic                      we;
    logic [SRI_ADDR_WIDTH-1:0] addr;
    logic [SRI_DATA_WIDTH-1:0] wdata;
    logic [SRI_BE_WIDTH-1:0]   be;
  } sri_req_t;

  // One SRI response broadcast back to the masters.
  typedef struct packed {
    logic                      valid;
    logic [SRI_DATA_WIDTH-1:0] rdata;
    logic                      error;
  } sri_rsp_t;

endpackage

// File: rtl/rr_arbiter_ptr.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping.
// Purely combinational; returns one-hot grant and the winner index.
module rr_arbiter_ptr #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int unsigned REQ_BITS = $clog2(NUM_REQ);

  // Scan from the pointer and take the first requester.
  always_comb begin
    logic [REQ_BITS-1:0] k;
    k       = '0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = REQ_BITS'((32'(ptr_i) + i) % NUM_REQ);
      if (!valid_o && req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = k;
        gnt_o   = NUM_REQ'(1) << k;
      end
    end
  end

endmodule

// File: rtl/riscv_dm_sri_arbiter.sv
// Round-robin arbiter sharing the DM SRI slave port between NUM_REQ masters.
// Optional macro RISCV_DM_SRI_ARB_PIPE_EN registers the granted request
// before the SRI port (sri_en_o one cycle after gnt_o).
module riscv_dm_sri_arbiter
  import riscv_dm_sri_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = SRI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SRI_DATA_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_en_i,
  input  logic [NUM_REQ-1:0]                req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_be_i,
  input  logic [NUM_REQ-1:0]                req_lock_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic                              rsp_error_o,
  output logic                              sri_en_o,
  output logic                              sri_we_o,
  output logic [ADDR_WIDTH-1:0]             sri_addr_o,
  output logic [DATA_WIDTH-1:0]             sri_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           sri_be_o,
  input  logic [DATA_WIDTH-1:0]             sri_rdata_i,
  input  logic                              sri_error_i
);

  localparam int unsigned REQ_BITS = $clog2(NUM_REQ);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [REQ_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_BITS-1:0] lock_owner_q, lock_owner_d;
  logic                lock_valid_q, lock_valid_d;
  logic [REQ_BITS-1:0] owner_q, owner_d;
  logic                rsp_pending_q, rsp_pending_d;

  logic [NUM_REQ-1:0]  rr_gnt;
  logic [REQ_BITS-1:0] rr_idx;
  logic                rr_valid;
  logic                lock_hit;
  logic                grant;
  logic [REQ_BITS-1:0] winner;
  sri_req_t            sel_req;
  sri_req_t            sri_req;
  sri_rsp_t            rsp;

  rr_arbiter_ptr #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (req_en_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  // Winner selection: a still-requesting lock owner overrides round-robin.
  always_comb begin
    lock_hit = lock_valid_q && req_en_i[lock_owner_q];
    grant    = !rst_i && (lock_hit || rr_valid);
    winner   = lock_hit ? lock_owner_q : rr_idx;
    gnt_o    = '0;
    if (grant) begin
      gnt_o = lock_hit ? (NUM_REQ'(1) << lock_owner_q) : rr_gnt;
    end
  end

  // Mux the winner's request slice; all-zero when nothing is granted.
  always_comb begin
    sel_req = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant && (winner == REQ_BITS'(k))) begin
        sel_req.en    = 1'b1;
        sel_req.we    = req_we_i[REQ_BITS'(k)];
        sel_req.addr  = SRI_ADDR_WIDTH'(ADDR_WIDTH'(req_addr_i >> (k * ADDR_WIDTH)));
        sel_req.wdata = SRI_DATA_WIDTH'(DATA_WIDTH'(req_wdata_i >> (k * DATA_WIDTH)));
        sel_req.be    = SRI_BE_WIDTH'(BE_WIDTH'(req_be_i >> (k * BE_WIDTH)));
      end
    end
  end

  // Pointer and lock bookkeeping; lock drops whenever the owner is not granted.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    lock_valid_d = 1'b0;
    if (grant) begin
      rr_ptr_d     = (winner == REQ_BITS'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      lock_owner_d = winner;
      lock_valid_d = req_lock_i[winner];
    end
  end

`ifdef RISCV_DM_SRI_ARB_PIPE_EN
  sri_req_t            pipe_q;
  logic [REQ_BITS-1:0] pipe_owner_q;

  // Pipeline stage between the arbiter and the SRI port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q       <= '0;
      pipe_owner_q <= '0;
    end else begin
      pipe_q       <= sel_req;
      pipe_owner_q <= winner;
    end
  end

  assign sri_req = rst_i ? '0 : pipe_q;
  assign owner_d = pipe_owner_q;
`else
  assign sri_req = sel_req;
  assign owner_d = winner;
`endif

  assign rsp_pending_d = sri_req.en;

  // Arbitration state and response owner tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q      <= '0;
      lock_owner_q  <= '0;
      lock_valid_q  <= 1'b0;
      owner_q       <= '0;
      rsp_pending_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      lock_owner_q  <= lock_owner_d;
      lock_valid_q  <= lock_valid_d;
      owner_q       <= owner_d;
      rsp_pending_q <= rsp_pending_d;
    end
  end

  // Response routing: DM data is valid the cycle after sri_en_o.
  always_comb begin
    rsp = '0;
    if (rsp_pending_q && !rst_i) begin
      rsp.valid = 1'b1;
      rsp.rdata = SRI_DATA_WIDTH'(sri_rdata_i);
      rsp.error = sri_error_i;
    end
  end

  assign sri_en_o    = sri_req.en;
  assign sri_we_o    = sri_req.we;
  assign sri_addr_o  = ADDR_WIDTH'(sri_req.addr);
  assign sri_wdata_o = DATA_WIDTH'(sri_req.wdata);
  assign sri_be_o    = BE_WIDTH'(sri_req.be);

  assign rsp_valid_o = rsp.valid ? (NUM_REQ'(1) << owner_q) : '0;
  assign rsp_rdata_o = DATA_WIDTH'(rsp.rdata);
  assign rsp_error_o = rsp.error;

endmodule

// File: tb/tb_riscv_dm_sri_arbiter.sv
// Bench for riscv_dm_sri_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_riscv_dm_sri_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = DW / 8;
`ifdef RISCV_DM_SRI_ARB_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [7:0]    owner;
  } acc_t;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_en, req_we, req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*BW-1:0] req_be;
  logic [NR-1:0]    gnt, rsp_valid;
  logic [DW-1:0]    rsp_rdata, sri_wdata, sri_rdata;
  logic             rsp_error, sri_en, sri_we, sri_error;
  logic [AW-1:0]    sri_addr;
  logic [BW-1:0]    sri_be;

  riscv_dm_sri_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_en_i(req_en), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_be_i(req_be), .req_lock_i(req_lock),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .sri_en_o(sri_en), .sri_we_o(sri_we),
    .sri_addr_o(sri_addr), .sri_wdata_o(sri_wdata), .sri_be_o(sri_be),
    .sri_rdata_i(sri_rdata), .sri_error_i(sri_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Master-side request state
  bit            m_en[NR], m_we[NR], m_lock[NR];
  logic [AW-1:0] m_addr[NR];
  logic [DW-1:0] m_wdata[NR];
  logic [BW-1:0] m_be[NR];

  // Reference model state
  int   rr = 0, lk_owner = 0;
  bit   lk_valid = 0;
  acc_t h1 = '0, h2 = '0;
  logic [NR-1:0] last_gnt;

  // Captured DUT outputs from the latest tick
  logic [NR-1:0] obs_gnt, obs_rsp_valid;
  logic          obs_sri_en, obs_we, obs_err;
  logic [AW-1:0] obs_addr;
  logic [BW-1:0] obs_be;
  logic [DW-1:0] obs_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < NR; k++) begin
      req_en[k]                = m_en[k];
      req_we[k]                = m_we[k];
      req_lock[k]              = m_lock[k];
      req_addr[k*AW +: AW]     = m_addr[k];
      req_wdata[k*DW +: DW]    = m_wdata[k];
      req_be[k*BW +: BW]       = m_be[k];
    end
  endtask

  // One clock cycle: drive, predict, compare mid-cycle, advance the model.
  task automatic tick();
    acc_t          cur, es, er;
    bit            any;
    int            win;
    logic [NR-1:0] eg, ev;
    apply();
    #4;
    any = 0;
    win = 0;
    if (!rst) begin
      if (lk_valid && m_en[lk_owner]) begin
        any = 1;
        win = lk_owner;
      end else begin
        for (int i = 0; i < NR; i++) begin
          int k;
          k = (rr + i) % NR;
          if (!any && m_en[k]) begin
            any = 1;
            win = k;
          end
        end
      end
    end
    cur = '0;
    if (any) begin
      cur.en    = 1'b1;
      cur.we    = m_we[win];
      cur.addr  = m_addr[win];
      cur.wdata = m_wdata[win];
      cur.be    = m_be[win];
      cur.owner = 8'(win);
    end
    es = PIPE ? h1 : cur;
    er = PIPE ? h2 : h1;
    if (rst) begin
      es = '0;
      er = '0;
    end
    eg = any ? (NR'(1) << win) : '0;
    ev = er.en ? (NR'(1) << er.owner) : '0;

    obs_gnt = gnt; obs_rsp_valid = rsp_valid; obs_sri_en = sri_en; obs_we = sri_we;
    obs_err = rsp_error; obs_addr = sri_addr; obs_be = sri_be; obs_rdata = rsp_rdata;

    check("gnt", 64'(gnt), 64'(eg));
    check("sri_en", 64'(sri_en), 64'(es.en));
    check("sri_we", 64'(sri_we), 64'(es.we));
    check("sri_addr", 64'(sri_addr), 64'(es.addr));
    check("sri_wdata", sri_wdata, es.wdata);
    check("sri_be", 64'(sri_be), 64'(es.be));
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    check("rsp_rdata", rsp_rdata, er.en ? sri_rdata : 64'h0);
    check("rsp_error", 64'(rsp_error), 64'(er.en ? sri_error : 1'b0));
    last_gnt = eg;

    @(posedge clk);
    if (rst) begin
      rr = 0; lk_valid = 0; h1 = '0; h2 = '0;
    end else begin
      h2 = h1;
      h1 = cur;
      if (any) begin
        rr = (win + 1) % NR;
        lk_owner = win;
        lk_valid = m_lock[win];
      end else begin
        lk_valid = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clear_masters();
    for (int k = 0; k < NR; k++) begin
      m_en[k] = 0; m_we[k] = 0; m_lock[k] = 0;
      m_addr[k] = '0; m_wdata[k] = '0; m_be[k] = '0;
    end
  endtask

  task automatic new_req(input int k);
    m_en[k]    = 1;
    m_we[k]    = 1'($urandom_range(0, 1));
    m_addr[k]  = AW'($urandom);
    m_wdata[k] = {$urandom, $urandom};
    m_be[k]    = BW'($urandom);
    m_lock[k]  = ($urandom_range(0, 3) == 0);
  endtask

  task automatic do_reset();
    clear_masters();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; sri_rdata = '0; sri_error = 0;
    clear_masters();
    tick();
    check("rst_gnt", 64'(obs_gnt), 64'h0);
    check("rst_rspv", 64'(obs_rsp_valid), 64'h0);
    tick();
    rst = 0;

`ifndef RISCV_DM_SRI_ARB_PIPE_EN
    // Single read from master 1
    m_en[1] = 1; m_addr[1] = 6'h05; sri_rdata = 64'hDEADBEEF;
    tick();
    check("t1_gnt", 64'(obs_gnt), 64'h2);
    check("t1_sri_en", 64'(obs_sri_en), 64'h1);
    check("t1_addr", 64'(obs_addr), 64'h05);
    m_en[1] = 0;
    tick();
    check("t1_rspv", 64'(obs_rsp_valid), 64'h2);
    check("t1_rdata", obs_rdata, 64'hDEADBEEF);

    // Both masters continuously: strict alternation
    do_reset();
    m_en[0] = 1; m_en[1] = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_gnt", 64'(obs_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i > 0) check("t2_rspv", 64'(obs_rsp_valid), (i % 2 == 0) ? 64'h2 : 64'h1);
    end

    // Lock held by master 0
    do_reset();
    m_en[0] = 1; m_lock[0] = 1; m_en[1] = 1;
    tick(); check("t3_gnt_a", 64'(obs_gnt), 64'h1);
    tick(); check("t3_gnt_b", 64'(obs_gnt), 64'h1);
    m_lock[0] = 0;
    tick(); check("t3_gnt_c", 64'(obs_gnt), 64'h1);
    tick(); check("t3_gnt_d", 64'(obs_gnt), 64'h2);

    // Write with byte enables and error response
    do_reset();
    m_en[0] = 1; m_we[0] = 1; m_be[0] = 8'h0F; m_addr[0] = 6'h03;
    tick();
    check("t4_we", 64'(obs_we), 64'h1);
    check("t4_be", 64'(obs_be), 64'h0F);
    m_en[0] = 0; sri_error = 1;
    tick();
    check("t4_rspv", 64'(obs_rsp_valid), 64'h1);
    check("t4_err", 64'(obs_err), 64'h1);
    sri_error = 0;

    // Reset right after a grant
    do_reset();
    m_en[0] = 1;
    tick();
    m_en[0] = 0; rst = 1;
    tick();
    check("t5_rspv_rst", 64'(obs_rsp_valid), 64'h0);
    rst = 0;
    tick();
    check("t5_rspv_after", 64'(obs_rsp_valid), 64'h0);
    m_en[0] = 1; m_en[1] = 1;
    tick();
    check("t5_gnt", 64'(obs_gnt), 64'h1);
`else
    // Pipelined timing: sri_en at t+1, response at t+2
    do_reset();
    m_en[0] = 1;
    tick();
    check("p_gnt0", 64'(obs_gnt), 64'h1);
    check("p_en0", 64'(obs_sri_en), 64'h0);
    m_en[0] = 0; m_en[1] = 1;
    tick();
    check("p_gnt1", 64'(obs_gnt), 64'h2);
    check("p_en1", 64'(obs_sri_en), 64'h1);
    m_en[1] = 0;
    tick();
    check("p_rspv0", 64'(obs_rsp_valid), 64'h1);
    check("p_en2", 64'(obs_sri_en), 64'h1);
    tick();
    check("p_rspv1", 64'(obs_rsp_valid), 64'h2);
`endif

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      sri_rdata = {$urandom, $urandom};
      sri_error = 1'($urandom_range(0, 1));
      tick();
      for (int k = 0; k < NR; k++) begin
        if (!m_en[k] || last_gnt[k]) begin
          if ($urandom_range(0, 3) != 0) new_req(k);
          else begin
            m_en[k] = 0;
            m_lock[k] = 0;
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
